bin2bcd_signed_seq: RTL and testbench
=====================================

Name: bin2bcd_signed_seq

Overview:
- Sequential signed-binary to packed-BCD converter that sits directly upstream of the 8-digit multiplexed seven-segment driver and produces its 32-bit `data_BCD` word.
- Takes the adder's two's-complement result and converts its magnitude by iterative double-dabble, one shift per clock.
- Applies optional leading-zero blanking and places the minus code next to the most significant digit shown.
- Output is held stable between conversions, so the display never shows intermediate values.

Parameters:
- IN_W, 24: input width (two's complement). The supported value, 24, gives range -8388608..8388607, whose magnitude fits in 7 BCD digits plus a sign digit.
- LZ_BLANK, 1: 1 = replace leading zeros with the blank code; 0 = show leading zeros.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  conversion request, sampled only in IDLE.
- bin_in  input  IN_W  signed operand, captured on the cycle start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  32  8 nibbles, digit7 = [31:28] ... digit0 = [3:0]; feeds the display's data_BCD.

Behaviour:
- Codes: 0-9 = digit, 4'hA = minus, 4'hF = blank.
- Reset (rst_n = 0 at a clk edge) forces:
  - state = IDLE, busy = 0, done = 0;
  - bcd_out = 32'hFFFF_FFF0 (display shows "0");
  - the internal shift/BCD registers are cleared.
- Reset applied mid-conversion aborts the conversion; no done pulse is produced.
- FSM states: IDLE -> SHIFT -> FORMAT -> IDLE.
- IDLE:
  - start = 1 at edge k captures sign = bin_in[IN_W-1] and mag = |bin_in| (IN_W-bit unsigned; -2^(IN_W-1) maps to 2^(IN_W-1) with no overflow).
  - Clears the 28-bit BCD accumulator, loads the shift counter = IN_W, sets busy = 1 from k+1.
- SHIFT, one iteration per cycle:
  - every accumulator nibble >= 5 gets +3;
  - then {acc, mag} shifts left by 1 and the counter decrements;
  - exactly IN_W cycles, leaving on counter == 1 -> FORMAT.
- FORMAT, one cycle:
  - locate the most significant non-zero digit p (p = 0 if the value is zero);
  - if LZ_BLANK = 1, digits above p become 4'hF;
  - if sign = 1, digit p+1 = 4'hA (p <= 6 always, so the minus fits; with LZ_BLANK = 0 the minus goes in digit7);
  - if sign = 0 and LZ_BLANK = 0, digit7 = 0;
  - bcd_out is written and done = 1 for one cycle, busy = 0 in that same cycle.
- Latency:
  - done is high in cycle k+IN_W+2 when start is sampled at edge k;
  - bcd_out changes only at that edge.
- start while busy (SHIFT/FORMAT) is ignored and not queued.
- start high in the done cycle is accepted (state is IDLE again), so back-to-back conversions run every IN_W+2 cycles.
- A level-held start restarts a conversion each time IDLE is reached.
- bin_in changes after capture have no effect.
- Negative zero cannot occur: for input 0, sign = 0.

Decomposition:
- Shared package ss_codes_pkg holds:
  - SS_MINUS = 4'hA, SS_BLANK = 4'hF;
  - SS_DIGITS = 8, BCD_MAG_DIGITS = 7;
  - state encoding localparams (IDLE = 2'd0, SHIFT = 2'd1, FORMAT = 2'd2).
- One natural sub-module: bcd_add3_digit, a combinational nibble correction (in >= 5 ? in+3 : in), instantiated 7 times in a generate loop.
- The FSM, the formatter and the leading-digit search stay in the top module.

Test Plan:
- Reset, then idle 5 cycles -> bcd_out = 32'hFFFF_FFF0, busy = 0, done = 0.
- bin_in = 1234, start pulse at edge k -> done only at cycle k+26, bcd_out = 32'hFFFF_1234; busy high in cycles k+1..k+25.
- bin_in = -5 -> bcd_out = 32'hFFFF_FFA5. bin_in = 0 -> 32'hFFFF_FFF0. bin_in = 8388607 -> 32'hF838_8607. bin_in = -8388608 -> 32'hA838_8608.
- LZ_BLANK = 0 build:
  - bin_in = 42 -> 32'h0000_0042;
  - bin_in = -42 -> 32'hA000_0042.
- Protocol and reset:
  - start for 1234; start again with bin_in = 99 at k+10 -> ignored, result 32'hFFFF_1234;
  - start with 99 in the done cycle -> 32'hFFFF_FF99 exactly 26 cycles later;
  - rst_n low at k+12 of a conversion -> no done, bcd_out = 32'hFFFF_FFF0, next start converts correctly.

Source files
------------

// File: rtl/ss_codes_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ss_codes_pkg
//  Description : Display codes, digit counts and FSM encoding shared by the
//                signed binary-to-BCD converter and its display neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package ss_codes_pkg;

  // Nibble codes understood by the seven-segment driver besides 0-9
  localparam logic [3:0] SS_MINUS = 4'hA;
  localparam logic [3:0] SS_BLANK = 4'hF;

  // Display is 8 digits; a 24-bit magnitude needs at most 7 of them,
  // leaving one position free for the minus sign.
  localparam int SS_DIGITS      = 8;
  localparam int BCD_MAG_DIGITS = 7;

  // Converter state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FORMAT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SHIFT  = SHIFT,
    ST_FORMAT = FORMAT
  } state_t;

endpackage : ss_codes_pkg
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3_digit
//  Description : Double-dabble nibble correction. A BCD digit of 5 or more
//                gets +3 so that the following left shift carries correctly
//                into the next decimal digit.
//  Ports       : i_digit [3:0]  BCD digit before the shift
//                o_digit [3:0]  corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3_digit
`default_nettype wire

// File: rtl/bin2bcd_signed_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_signed_seq
//  Description : Sequential two's-complement to packed-BCD converter feeding
//                the 8-digit seven-segment driver. The magnitude is converted
//                by double-dabble, one bit per clock, then formatted with
//                optional leading-zero blanking and a minus code placed just
//                left of the most significant digit shown. bcd_out only moves
//                on the done edge, so the display never sees partial values.
//  Ports       : clk      system clock, rising edge
//                rst_n    synchronous active-low reset
//                start    conversion request, honoured only when idle
//                bin_in   signed operand, captured when start is accepted
//                busy     conversion in progress
//                done     one-cycle pulse, bcd_out updated at the same edge
//                bcd_out  8 nibbles, digit7 = [31:28] .. digit0 = [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_signed_seq
  import ss_codes_pkg::*;
#(
  parameter int IN_W     = 24,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [IN_W-1:0]        bin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*SS_DIGITS-1:0] bcd_out
);

  localparam int c_CNT_W = $clog2(IN_W + 1);
  localparam int c_ACC_W = 4 * BCD_MAG_DIGITS;
  localparam int c_OUT_W = 4 * SS_DIGITS;

  // "0" right-aligned, every other position blank
  localparam logic [c_OUT_W-1:0] c_RESET_BCD = {{(SS_DIGITS-1){SS_BLANK}}, 4'h0};

  state_t             r_state;
  state_t             w_state_next;
  logic [IN_W-1:0]    r_mag;
  logic [c_ACC_W-1:0] r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sign;
  logic [c_OUT_W-1:0] r_bcd;
  logic               r_done;

  logic [IN_W-1:0]    w_mag_in;
  logic [c_ACC_W-1:0] w_acc_adj;
  logic [2:0]         w_lead;
  logic [c_OUT_W-1:0] w_bcd_fmt;

  // Magnitude of the operand. The most negative value wraps onto
  // 2^(IN_W-1), which is still correct when read as unsigned.
  assign w_mag_in = bin_in[IN_W-1] ? ((~bin_in) + IN_W'(1)) : bin_in;

  // Per-digit +3 correction applied before every shift
  for (genvar g = 0; g < BCD_MAG_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_acc_adj[4*g +: 4])
    );
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Counter was loaded with IN_W, so reaching 1 marks the last shift
        if (r_cnt == c_CNT_W'(1)) begin
          w_state_next = ST_FORMAT;
        end
      end
      ST_FORMAT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- Datapath ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_bcd  <= c_RESET_BCD;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sign <= bin_in[IN_W-1];
            r_mag  <= w_mag_in;
            r_acc  <= '0;
            r_cnt  <= c_CNT_W'(IN_W);
          end
        end
        ST_SHIFT: begin
          r_acc <= {w_acc_adj[c_ACC_W-2:0], r_mag[IN_W-1]};
          r_mag <= {r_mag[IN_W-2:0], 1'b0};
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
        ST_FORMAT: begin
          r_bcd  <= w_bcd_fmt;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------- Formatting ----
  // Highest non-zero digit; digit 0 is always shown, so zero yields 0.
  always_comb begin
    w_lead = 3'd0;
    for (int i = 1; i < BCD_MAG_DIGITS; i++) begin
      if (r_acc[4*i +: 4] != 4'h0) begin
        w_lead = 3'(i);
      end
    end
  end

  always_comb begin
    w_bcd_fmt = {(LZ_BLANK ? SS_BLANK : 4'h0), r_acc};
    if (LZ_BLANK) begin
      for (int i = 1; i < BCD_MAG_DIGITS; i++) begin
        if (3'(i) > w_lead) begin
          w_bcd_fmt[4*i +: 4] = SS_BLANK;
        end
      end
    end
    if (r_sign) begin
      // Magnitude never uses more than 7 digits, so lead+1 <= 7 always fits
      if (LZ_BLANK) begin
        w_bcd_fmt[4*(int'(w_lead) + 1) +: 4] = SS_MINUS;
      end else begin
        w_bcd_fmt[c_OUT_W-1 -: 4] = SS_MINUS;
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule : bin2bcd_signed_seq
`default_nettype wire

// File: tb/tb_bin2bcd_signed_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_signed_seq
//  Description : Self-checking bench for bin2bcd_signed_seq. A blanking and a
//                non-blanking build share the stimulus; each has a queue of
//                expected words consumed whenever its done pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_signed_seq;

  localparam int NONE = -10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] bin_in;
  logic        busy1, done1, busy0, done0;
  logic [31:0] bcd1, bcd0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] exp1, exp0;

  always #5 clk = ~clk;

  bin2bcd_signed_seq #(.IN_W(24), .LZ_BLANK(1'b1)) u_dut_lz1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy1),
    .done    (done1),
    .bcd_out (bcd1)
  );

  bin2bcd_signed_seq #(.IN_W(24), .LZ_BLANK(1'b0)) u_dut_lz0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy0),
    .done    (done0),
    .bcd_out (bcd0)
  );

  // Reference formatter working in decimal arithmetic
  function automatic logic [31:0] model(input longint v, input bit lz);
    longint      m;
    int          d[7];
    int          p;
    bit          s;
    logic [31:0] r;
    s = (v < 0);
    m = s ? -v : v;
    for (int i = 0; i < 7; i++) begin
      d[i] = int'(m % 10);
      m    = m / 10;
    end
    p = 0;
    for (int i = 0; i < 7; i++) if (d[i] != 0) p = i;
    r = lz ? 32'hFFFF_FFFF : 32'h0;
    for (int i = 0; i < 7; i++) if (!lz || i <= p) r[i*4 +: 4] = 4'(d[i]);
    if (s) begin
      if (lz) r[(p+1)*4 +: 4] = 4'hA;
      else    r[31:28] = 4'hA;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done1 === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected_lz1: bcd_out=%h with nothing pending", bcd1);
        end else begin
          exp1 = q1.pop_front();
          if (bcd1 !== exp1) begin
            errors++;
            $display("FAIL result_lz1: got %h expected %h", bcd1, exp1);
          end
        end
      end
      if (done0 === 1'b1) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected_lz0: bcd_out=%h with nothing pending", bcd0);
        end else begin
          exp0 = q0.pop_front();
          if (bcd0 !== exp0) begin
            errors++;
            $display("FAIL result_lz0: got %h expected %h", bcd0, exp0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one conversion starting now (1 time unit after an edge) and return
  // in the done cycle. inject_at / abort_at are observation indices after the
  // capturing edge at which a stray start or a reset is applied.
  task automatic run_conv(input int value, input logic [31:0] e1, input logic [31:0] e0,
                          input int inject_at, input int abort_at);
    int          n;
    logic [31:0] prev1, prev0;
    prev1  = bcd1;
    prev0  = bcd0;
    bin_in = value[23:0];
    start  = 1'b1;
    q1.push_back(e1);
    q0.push_back(e0);
    tick();
    start = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      if (n == abort_at + 1) begin
        checks++;
        if (bcd1 !== 32'hFFFF_FFF0 || bcd0 !== 32'hFFFF_FFF0) begin
          errors++;
          $display("FAIL abort_bcd: got %h/%h expected ffff_fff0", bcd1, bcd0);
        end
        checks++;
        if (busy1 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
          errors++;
          $display("FAIL abort_flags: busy=%b/%b done0=%b expected 0", busy1, busy0, done0);
        end
        rst_n = 1'b1;
        q1.delete();
        q0.delete();
        return;
      end
      checks++;
      if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL busy_during_conv: cycle %0d busy=%b/%b expected 1", n, busy1, busy0);
      end
      checks++;
      if (bcd1 !== prev1 || bcd0 !== prev0) begin
        errors++;
        $display("FAIL bcd_held: cycle %0d got %h/%h expected %h/%h", n, bcd1, bcd0, prev1, prev0);
      end
      if (n == 3) bin_in = 24'($urandom);
      if (n == inject_at) begin
        start  = 1'b1;
        bin_in = 24'd99;
      end
      if (n == inject_at + 1) start = 1'b0;
      if (n == abort_at) rst_n = 1'b0;
      tick();
      n++;
    end
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end else begin
      if (n != 25) begin
        errors++;
        $display("FAIL latency: done after %0d edges expected 25", n);
      end
      checks++;
      if (busy1 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b1) begin
        errors++;
        $display("FAIL done_cycle_flags: busy=%b/%b done0=%b expected 0/0/1", busy1, busy0, done0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 24'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (bcd1 !== 32'hFFFF_FFF0 || bcd0 !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL reset_bcd: got %h/%h expected ffff_fff0", bcd1, bcd0);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b/%b done=%b/%b expected 0", busy1, busy0, done1, done0);
    end
  endtask

  task automatic test_latency();
    run_conv(1234, 32'hFFFF_1234, 32'h0000_1234, NONE, NONE);
    repeat (3) tick();
  endtask

  task automatic test_values();
    logic [23:0] rv;
    int          v;
    run_conv(-5,       32'hFFFF_FFA5, 32'hA000_0005, NONE, NONE);
    run_conv(0,        32'hFFFF_FFF0, 32'h0000_0000, NONE, NONE);
    run_conv(8388607,  32'hF838_8607, 32'h0838_8607, NONE, NONE);
    run_conv(-8388608, 32'hA838_8608, 32'hA838_8608, NONE, NONE);
    for (int i = 0; i < 6; i++) begin
      rv = 24'($urandom);
      if (i < 2) rv = 24'($urandom_range(0, 999)) ^ {24{rv[23]}};
      v = int'($signed(rv));
      run_conv(v, model(longint'(v), 1'b1), model(longint'(v), 1'b0), NONE, NONE);
    end
  endtask

  task automatic test_no_blank();
    run_conv(42,  model(42, 1'b1),  32'h0000_0042, NONE, NONE);
    run_conv(-42, model(-42, 1'b1), 32'hA000_0042, NONE, NONE);
  endtask

  task automatic test_ignore_busy();
    run_conv(1234, 32'hFFFF_1234, 32'h0000_1234, 9, NONE);
    repeat (30) tick();
  endtask

  task automatic test_back_to_back();
    run_conv(1234, 32'hFFFF_1234, 32'h0000_1234, NONE, NONE);
    run_conv(99,   32'hFFFF_FF99, 32'h0000_0099, NONE, NONE);
    run_conv(-7,   32'hFFFF_FFA7, 32'hA000_0007, NONE, NONE);
    repeat (3) tick();
  endtask

  task automatic test_reset_abort();
    run_conv(5678, 32'hFFFF_5678, 32'h0000_5678, NONE, 11);
    repeat (30) tick();
    run_conv(777, 32'hFFFF_F777, 32'h0000_0777, NONE, NONE);
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_no_blank();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    repeat (30) tick();
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d/%0d expected 0", q1.size(), q0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bin2bcd_signed_seq
`default_nettype wire
